// File: rtl/ddr3_app_arbiter.sv
// Two-port round-robin arbiter in front of the DDR3 controller app interface.
// One full-burst command in flight at a time; read data is routed back through an in-order tag FIFO.
module ddr3_app_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_calib_complete,
  input  logic                p0_req_valid,
  output logic                p0_req_ready,
  input  logic                p0_req_we,
  input  logic [ADDR_W-1:0]   p0_req_addr,
  input  logic [DATA_W-1:0]   p0_req_wdata,
  input  logic [DATA_W/8-1:0] p0_req_wmask,
  output logic                p0_rd_valid,
  output logic [DATA_W-1:0]   p0_rd_data,
  input  logic                p1_req_valid,
  output logic                p1_req_ready,
  input  logic                p1_req_we,
  input  logic [ADDR_W-1:0]   p1_req_addr,
  input  logic [DATA_W-1:0]   p1_req_wdata,
  input  logic [DATA_W/8-1:0] p1_req_wmask,
  output logic                p1_rd_valid,
  output logic [DATA_W-1:0]   p1_rd_data,
  output logic [2:0]          app_cmd,
  output logic                app_cmd_en,
  output logic [ADDR_W-1:0]   app_addr,
  input  logic                app_cmd_rdy,
  output logic [DATA_W-1:0]   app_wdata,
  output logic [DATA_W/8-1:0] app_wdata_mask,
  output logic                app_wdata_en,
  output logic                app_wdata_end,
  input  logic                app_wdata_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  output logic                tag_overflow
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(TAG_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                rr_q, rr_d;
  logic [TAG_DEPTH-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                rd_valid0_q, rd_valid0_d;
  logic                rd_valid1_q, rd_valid1_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                overflow_q, overflow_d;

  logic full, empty, elig0, elig1, sel, issue, accept, push, pop, head_tag;

  always_comb begin
    full     = (count_q == CNT_W'(TAG_DEPTH));
    empty    = (count_q == '0);
    // Eligibility looks at the occupancy before any push/pop of this cycle.
    elig0    = p0_req_valid & (p0_req_we | ~full);
    elig1    = p1_req_valid & (p1_req_we | ~full);
    sel      = (elig0 & elig1) ? rr_q : elig1;
    issue    = (state_q == ISSUE);
    accept   = issue & app_cmd_rdy & (~we_q | app_wdata_rdy);
    push     = accept & ~we_q;
    pop      = app_rd_data_valid & ~empty;
    head_tag = tag_q[rd_ptr_q];

    state_d    = state_q;
    grant_d    = grant_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rr_d       = rr_q;
    tag_d      = tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q | (app_rd_data_valid & empty);

    case (state_q)
      IDLE: begin
        if (init_calib_complete & (elig0 | elig1)) begin
          grant_d = sel;
          we_d    = sel ? p1_req_we    : p0_req_we;
          addr_d  = sel ? p1_req_addr  : p0_req_addr;
          wdata_d = sel ? p1_req_wdata : p0_req_wdata;
          wmask_d = sel ? p1_req_wmask : p0_req_wmask;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          rr_d    = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      tag_d[wr_ptr_q] = grant_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = app_rd_data;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    rd_valid0_d = pop & ~head_tag;
    rd_valid1_d = pop & head_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rr_q        <= 1'b0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rr_q        <= rr_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid0_q <= rd_valid0_d;
      rd_valid1_q <= rd_valid1_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign app_cmd_en     = issue;
  assign app_cmd        = {2'b00, issue & ~we_q};
  assign app_addr       = addr_q;
  assign app_wdata      = wdata_q;
  assign app_wdata_mask = wmask_q;
  assign app_wdata_en   = issue & we_q;
  assign app_wdata_end  = issue & we_q;
  assign p0_req_ready   = accept & ~grant_q;
  assign p1_req_ready   = accept & grant_q;
  assign p0_rd_valid    = rd_valid0_q;
  assign p1_rd_valid    = rd_valid1_q;
  assign p0_rd_data     = rd_data_q;
  assign p1_rd_data     = rd_data_q;
  assign tag_overflow   = overflow_q;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Bench for ddr3_app_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model (request queues, outstanding-tag queue, round-robin preference).
module tb_ddr3_app_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = DW / 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
  } req_t;

  logic clk = 1'b0;
  logic rst, init_calib_complete;
  logic p0_req_valid, p0_req_ready, p0_req_we, p0_rd_valid;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata, p0_rd_data;
  logic [MW-1:0] p0_req_wmask;
  logic p1_req_valid, p1_req_ready, p1_req_we, p1_rd_valid;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata, p1_rd_data;
  logic [MW-1:0] p1_req_wmask;
  logic [2:0] app_cmd;
  logic app_cmd_en, app_cmd_rdy, app_wdata_en, app_wdata_end, app_wdata_rdy;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] app_wdata, app_rd_data;
  logic [MW-1:0] app_wdata_mask;
  logic app_rd_data_valid, tag_overflow;

  ddr3_app_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wmask(p0_req_wmask),
    .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wmask(p1_req_wmask),
    .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
    .app_cmd(app_cmd), .app_cmd_en(app_cmd_en), .app_addr(app_addr), .app_cmd_rdy(app_cmd_rdy),
    .app_wdata(app_wdata), .app_wdata_mask(app_wdata_mask), .app_wdata_en(app_wdata_en),
    .app_wdata_end(app_wdata_end), .app_wdata_rdy(app_wdata_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .tag_overflow(tag_overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Stimulus knobs and requester queues
  req_t p0q[$];
  req_t p1q[$];
  int calib_pct, cmd_rdy_pct, wdata_rdy_pct, ret_pct;
  bit force_ret;
  logic [DW-1:0] force_data;

  // Reference model state
  bit            m_issue;
  int            m_port;
  req_t          m_cmd;
  int            m_rr;
  int            m_tags[$];
  bit            m_ovf;
  bit            m_rdv[2];
  logic [DW-1:0] m_rdd;
  bit            m_done[2];
  int            grants[$];
  int            rp[2];

  function automatic req_t mk_req(input logic we, input logic [AW-1:0] addr);
    req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = {$urandom, $urandom, $urandom, $urandom};
    r.mask  = MW'($urandom);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    init_calib_complete = 1'b0;
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_wdata = '0; p0_req_wmask = '0;
    p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_wdata = '0; p1_req_wmask = '0;
    app_cmd_rdy = 1'b0; app_wdata_rdy = 1'b0; app_rd_data_valid = 1'b0; app_rd_data = '0;
    force_ret = 1'b0; force_data = '0;
    calib_pct = 100; cmd_rdy_pct = 100; wdata_rdy_pct = 100; ret_pct = 0;
    p0q.delete(); p1q.delete(); m_tags.delete(); grants.delete();
    m_issue = 1'b0; m_port = 0; m_rr = 0; m_ovf = 1'b0;
    m_rdv[0] = 1'b0; m_rdv[1] = 1'b0; m_done[0] = 1'b0; m_done[1] = 1'b0;
    rp[0] = 0; rp[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of traffic: check registered outputs, drive new inputs, check ready, advance model.
  task automatic run_cycle();
    bit acc, full, e0, e1;
    int sel, port;
    logic [2:0] exp_cmd;
    @(negedge clk);
    tests++;
    if (app_cmd_en !== m_issue || (!m_issue && app_wdata_en !== 1'b0)) begin
      fails++;
      $display("[TB] FAIL cmd_en: got en=%0b wen=%0b, expected en=%0b", app_cmd_en, app_wdata_en, m_issue);
    end
    if (m_issue) begin
      exp_cmd = m_cmd.we ? 3'b000 : 3'b001;
      tests++;
      if (app_addr !== m_cmd.addr || app_cmd !== exp_cmd || app_wdata_en !== m_cmd.we ||
          app_wdata_end !== m_cmd.we ||
          (m_cmd.we && (app_wdata !== m_cmd.wdata || app_wdata_mask !== m_cmd.mask))) begin
        fails++;
        $display("[TB] FAIL cmd_payload: got cmd=%0d addr=%h wen=%0b, expected cmd=%0d addr=%h wen=%0b",
                 app_cmd, app_addr, app_wdata_en, exp_cmd, m_cmd.addr, m_cmd.we);
      end
    end
    tests++;
    if (p0_rd_valid !== m_rdv[0] || p1_rd_valid !== m_rdv[1]) begin
      fails++;
      $display("[TB] FAIL rd_valid: got %0b%0b, expected %0b%0b", p0_rd_valid, p1_rd_valid, m_rdv[0], m_rdv[1]);
    end
    if (m_rdv[0] || m_rdv[1]) begin
      tests++;
      if (p0_rd_data !== m_rdd || p1_rd_data !== m_rdd) begin
        fails++;
        $display("[TB] FAIL rd_data: got %h / %h, expected %h", p0_rd_data, p1_rd_data, m_rdd);
      end
    end
    tests++;
    if (tag_overflow !== m_ovf) begin
      fails++;
      $display("[TB] FAIL tag_overflow: got %0b, expected %0b", tag_overflow, m_ovf);
    end

    if (m_done[0]) void'(p0q.pop_front());
    if (m_done[1]) void'(p1q.pop_front());
    m_done[0] = 1'b0; m_done[1] = 1'b0;
    p0_req_valid = (p0q.size() > 0);
    if (p0q.size() > 0) begin
      p0_req_we = p0q[0].we; p0_req_addr = p0q[0].addr; p0_req_wdata = p0q[0].wdata; p0_req_wmask = p0q[0].mask;
    end
    p1_req_valid = (p1q.size() > 0);
    if (p1q.size() > 0) begin
      p1_req_we = p1q[0].we; p1_req_addr = p1q[0].addr; p1_req_wdata = p1q[0].wdata; p1_req_wmask = p1q[0].mask;
    end
    init_calib_complete = ($urandom_range(99) < calib_pct);
    app_cmd_rdy   = ($urandom_range(99) < cmd_rdy_pct);
    app_wdata_rdy = ($urandom_range(99) < wdata_rdy_pct);
    app_rd_data   = force_ret ? force_data : {$urandom, $urandom, $urandom, $urandom};
    app_rd_data_valid = force_ret || (m_tags.size() > 0 && $urandom_range(99) < ret_pct);
    #1;

    acc = m_issue && app_cmd_rdy && (!m_cmd.we || app_wdata_rdy);
    tests++;
    if (p0_req_ready !== (acc && m_port == 0) || p1_req_ready !== (acc && m_port == 1)) begin
      fails++;
      $display("[TB] FAIL req_ready: got %0b%0b, expected %0b%0b", p0_req_ready, p1_req_ready,
               acc && m_port == 0, acc && m_port == 1);
    end
    if (p0_req_ready) rp[0]++;
    if (p1_req_ready) rp[1]++;

    full = (m_tags.size() >= 8);
    m_rdv[0] = 1'b0; m_rdv[1] = 1'b0;
    if (app_rd_data_valid) begin
      if (m_tags.size() > 0) begin
        port = m_tags.pop_front();
        m_rdv[port] = 1'b1;
        m_rdd = app_rd_data;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (m_issue) begin
      if (acc) begin
        if (!m_cmd.we) m_tags.push_back(m_port);
        m_rr = 1 - m_port;
        m_issue = 1'b0;
        m_done[m_port] = 1'b1;
        grants.push_back(m_port);
      end
    end else if (init_calib_complete) begin
      e0 = p0_req_valid && (p0_req_we || !full);
      e1 = p1_req_valid && (p1_req_we || !full);
      if (e0 || e1) begin
        sel = (e0 && e1) ? m_rr : (e1 ? 1 : 0);
        m_issue = 1'b1;
        m_port = sel;
        m_cmd = (sel == 1) ? p1q[0] : p0q[0];
      end
    end
  endtask

  task automatic drain(input int max_cyc, input string name);
    int n = 0;
    while ((p0q.size() > 0 || p1q.size() > 0 || m_issue || (ret_pct > 0 && m_tags.size() > 0)) && n < max_cyc) begin
      run_cycle();
      n++;
    end
    tests++;
    if (n >= max_cyc) begin
      fails++;
      $display("[TB] FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (app_cmd_en !== 1'b0 || app_cmd !== 3'b000 || app_addr !== '0 || app_wdata_en !== 1'b0 ||
        app_wdata_end !== 1'b0 || app_wdata !== '0 || app_wdata_mask !== '0) begin
      fails++;
      $display("[TB] FAIL reset_app: got en=%0b cmd=%0d addr=%h, expected all 0", app_cmd_en, app_cmd, app_addr);
    end
    tests++;
    if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0 || p0_rd_valid !== 1'b0 || p1_rd_valid !== 1'b0 ||
        p0_rd_data !== '0 || p1_rd_data !== '0 || tag_overflow !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ports: got rdy=%0b%0b rdv=%0b%0b ovf=%0b, expected all 0",
               p0_req_ready, p1_req_ready, p0_rd_valid, p1_rd_valid, tag_overflow);
    end
  endtask

  task automatic test_calib_gate();
    int lat = 0;
    do_reset();
    calib_pct = 0;
    p0q.push_back(mk_req(1'b1, AW'($urandom)));
    repeat (20) run_cycle();
    tests++;
    if (rp[0] != 0 || grants.size() != 0) begin
      fails++;
      $display("[TB] FAIL calib_hold: got %0d grants, expected 0", grants.size());
    end
    calib_pct = 100;
    while (lat < 5 && app_cmd_en !== 1'b1) begin
      run_cycle();
      lat++;
    end
    tests++;
    if (lat != 2) begin
      fails++;
      $display("[TB] FAIL calib_latency: got %0d cycles, expected 2", lat);
    end
    drain(20, "calib");
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      p0q.push_back(mk_req(1'b1, AW'($urandom)));
      p1q.push_back(mk_req(1'b1, AW'($urandom)));
    end
    drain(100, "alternate");
    tests++;
    if (grants.size() != 16) begin
      fails++;
      $display("[TB] FAIL alt_count: got %0d grants, expected 16", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      tests++;
      if (grants[i] != (i % 2)) begin
        fails++;
        $display("[TB] FAIL alt_order[%0d]: got port %0d, expected port %0d", i, grants[i], i % 2);
      end
    end
  endtask

  task automatic test_read_routing();
    logic [DW-1:0] d0, d1;
    do_reset();
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    p0q.push_back(mk_req(1'b0, AW'('h40)));
    p1q.push_back(mk_req(1'b0, AW'('h80)));
    drain(20, "read_issue");
    force_ret = 1'b1; force_data = d0;
    run_cycle();
    force_data = d1;
    run_cycle();
    tests++;
    if (p0_rd_valid !== 1'b1 || p1_rd_valid !== 1'b0 || p0_rd_data !== d0) begin
      fails++;
      $display("[TB] FAIL route_p0: got v=%0b%0b data=%h, expected v=10 data=%h", p0_rd_valid, p1_rd_valid, p0_rd_data, d0);
    end
    force_ret = 1'b0;
    run_cycle();
    tests++;
    if (p0_rd_valid !== 1'b0 || p1_rd_valid !== 1'b1 || p1_rd_data !== d1) begin
      fails++;
      $display("[TB] FAIL route_p1: got v=%0b%0b data=%h, expected v=01 data=%h", p0_rd_valid, p1_rd_valid, p1_rd_data, d1);
    end
    run_cycle();
  endtask

  task automatic test_cmd_stall();
    int n = 0;
    do_reset();
    cmd_rdy_pct = 0;
    p0q.push_back(mk_req(1'b1, AW'($urandom)));
    while (!m_issue && n < 5) begin
      run_cycle();
      n++;
    end
    repeat (5) run_cycle();
    cmd_rdy_pct = 100;
    drain(10, "stall");
    tests++;
    if (rp[0] != 1 || rp[1] != 0) begin
      fails++;
      $display("[TB] FAIL stall_ready: got %0d/%0d pulses, expected 1/0", rp[0], rp[1]);
    end
  endtask

  task automatic test_tag_full();
    int r0, r1;
    do_reset();
    for (int i = 0; i < 8; i++) p0q.push_back(mk_req(1'b0, AW'($urandom)));
    drain(40, "fill");
    r0 = rp[0]; r1 = rp[1];
    p0q.push_back(mk_req(1'b0, AW'($urandom)));
    p1q.push_back(mk_req(1'b1, AW'($urandom)));
    repeat (10) run_cycle();
    tests++;
    if (rp[0] - r0 != 0 || rp[1] - r1 != 1) begin
      fails++;
      $display("[TB] FAIL full_block: got p0=%0d p1=%0d grants, expected p0=0 p1=1", rp[0] - r0, rp[1] - r1);
    end
    force_ret = 1'b1; force_data = {$urandom, $urandom, $urandom, $urandom};
    run_cycle();
    force_ret = 1'b0;
    drain(20, "unblock");
    tests++;
    if (rp[0] - r0 != 1) begin
      fails++;
      $display("[TB] FAIL full_release: got %0d p0 grants, expected 1", rp[0] - r0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    force_ret = 1'b1;
    run_cycle();
    force_ret = 1'b0;
    repeat (3) run_cycle();
    tests++;
    if (tag_overflow !== 1'b1 || p0_rd_valid !== 1'b0 || p1_rd_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL overflow_set: got ovf=%0b rdv=%0b%0b, expected ovf=1 rdv=00", tag_overflow, p0_rd_valid, p1_rd_valid);
    end
    do_reset();
    tests++;
    if (tag_overflow !== 1'b0) begin
      fails++;
      $display("[TB] FAIL overflow_clear: got %0b, expected 0", tag_overflow);
    end
  endtask

  task automatic test_reset_mid_issue();
    int n = 0;
    do_reset();
    cmd_rdy_pct = 0;
    p0q.push_back(mk_req(1'b1, AW'($urandom)));
    while (!m_issue && n < 5) begin
      run_cycle();
      n++;
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (app_cmd_en !== 1'b0 || app_wdata_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: got cmd_en=%0b wen=%0b, expected 0", app_cmd_en, app_wdata_en);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    calib_pct = 90; cmd_rdy_pct = 60; wdata_rdy_pct = 70; ret_pct = 40;
    for (int i = 0; i < 30; i++) begin
      p0q.push_back(mk_req(1'($urandom), AW'($urandom)));
      p1q.push_back(mk_req(1'($urandom), AW'($urandom)));
    end
    drain(4000, "random");
    tests++;
    if (grants.size() != 60) begin
      fails++;
      $display("[TB] FAIL random_count: got %0d commands, expected 60", grants.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_calib_gate();
    test_alternate();
    test_read_routing();
    test_cmd_stall();
    test_tag_full();
    test_overflow();
    test_reset_mid_issue();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
